// File: rtl/serial_half_sub.sv
// serial_half_sub: bit-serial a - b - bin, LSB first, one half-subtractor pair plus a borrow FF.
// Define SERIAL_HALF_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_half_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_HALF_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_brw, w_d, w_brw, w_last, w_accept;
    assign w_d      = r_a[0] ^ r_b[0] ^ r_brw;
    assign w_brw    = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = in_valid & in_ready;
    assign diff     = r_diff;
    assign bout     = r_brw;
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                w_next   = in_valid ? S_SHIFT : S_IDLE;
            end
            S_SHIFT: begin
                busy   = 1'b1;
                w_next = w_last ? S_DONE : S_SHIFT;
            end
            S_DONE: begin
                out_valid = 1'b1;
                w_next    = out_ready ? S_IDLE : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end
    // Difference bits enter at the MSB so bit i settles at position i after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_brw  <= bin;
            r_diff <= '0;
            r_cnt  <= '0;
        end else if (busy) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_brw  <= w_brw;
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            r_cnt  <= r_cnt + CW'(1);
        end
    end
`ifdef SERIAL_HALF_SUB_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;
    // On the last shift the LSBs of A/B hold the original operand MSBs and w_d is the result MSB.
    always_ff @(posedge clk) begin
        if (!rst_n)              r_ovf <= 1'b0;
        else if (w_accept)       r_ovf <= 1'b0;
        else if (busy && w_last) r_ovf <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
    end
`endif
endmodule

// File: tb/tb_serial_half_sub.sv
// tb_serial_half_sub: scoreboard bench for serial_half_sub; checks ovf when SERIAL_HALF_SUB_OVF_EN is defined.
module tb_serial_half_sub;
    localparam int W = 8;
    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, bin = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, bout, busy;
    logic [W-1:0] diff;
    int           n_vec = 0, n_err = 0;
    logic [W+1:0] sb_q[$];
    logic [W+1:0] sb_e;
`ifdef SERIAL_HALF_SUB_OVF_EN
    logic ovf;
`endif

    serial_half_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .busy(busy)
`ifdef SERIAL_HALF_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} - {1'b0, y} - (W+1)'(c);
        v = (x[W-1] ^ y[W-1]) & (t[W-1] ^ x[W-1]);
        return {v, t[W], t[W-1:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) sb_q.delete();
        else begin
            if (in_valid && in_ready) sb_q.push_back(model(a, b, bin));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    sb_e = sb_q.pop_front();
                    chk("diff", 32'(diff), 32'(sb_e[W-1:0]));
                    chk("bout", 32'(bout), 32'(sb_e[W]));
`ifdef SERIAL_HALF_SUB_OVF_EN
                    chk("ovf", 32'(ovf), 32'(sb_e[W+1]));
`endif
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        int k = 0;
        a = ia; b = ib; bin = ibin; in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (lat == 0)     chk("busy_first", 32'(busy), 1);
            if (lat == W - 1) chk("busy_last", 32'(busy), 1);
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        int lat;
        send(ia, ib, ibin);
        wait_out(lat);
        chk("latency", lat, W);
        chk("done_not_busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("ready_after_hs", 32'(in_ready), 1);
        chk("valid_after_hs", 32'(out_valid), 0);
    endtask

    initial begin
        int           lat, bad;
        logic [W-1:0] d0;
        logic         b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);
`ifdef SERIAL_HALF_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif
        rst_n = 1'b1;
        op(8'h5A, 8'h3C, 1'b0);
        op(8'h00, 8'h01, 1'b0);
        op(8'h10, 8'h0F, 1'b1);
        op(8'h00, 8'h00, 1'b1);
        op(8'hFF, 8'hFF, 1'b0);
        // Backpressure: result must hold for 20 cycles
        out_ready = 1'b0;
        send(8'hC3, 8'h3D, 1'b1);
        wait_out(lat);
        chk("bp_latency", lat, W);
        chk("bp_diff", 32'(diff), 32'h85);
        chk("bp_bout", 32'(bout), 0);
        d0 = diff; b0 = bout; bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (diff !== d0 || bout !== b0 || !out_valid || in_ready) bad++;
        end
        chk("bp_stable", bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after", 32'(in_ready), 1);
        chk("bp_valid_after", 32'(out_valid), 0);
        // Requests and operand changes during SHIFT must be ignored
        send(8'h12, 8'h34, 1'b0);
        in_valid = 1'b1; a = 8'hFF; bad = 0;
        for (int i = 0; i < W - 1; i++) begin
            if (in_ready) bad++;
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        end
        in_valid = 1'b0;
        chk("ignore_ready_low", bad, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("ignore_got_out", 32'(out_valid), 1);
        chk("ignore_diff", 32'(diff), 32'hDE);
        bad = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (out_valid || busy) bad++;
        end
        chk("ignore_no_extra", bad, 0);
        // Reset during SHIFT cycle 3 abandons the operation
        send(8'h44, 8'h11, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst_in_ready", 32'(in_ready), 1);
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_diff", 32'(diff), 0);
        op(8'h03, 8'h05, 1'b0);
        op(8'h80, 8'h01, 1'b0);
        op(8'h7F, 8'hFF, 1'b0);
        op(8'h05, 8'h03, 1'b0);
        for (int i = 0; i < 8; i++) op(W'($urandom), W'($urandom), 1'($urandom));
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/serial_half_sub.md
# serial_half_sub

Bit-serial subtractor built from a single half-subtractor cell pair and a borrow flip-flop. It accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake, then computes a − b − bin LSB-first over WIDTH cycles. It returns the difference and borrow-out through a second valid/ready handshake. It is the subtracting counterpart of the gate-level adder cells and full-adder harness, and is intended for area-constrained arithmetic paths.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands present on a, b, bin.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
- busy  output  1  high while in the SHIFT state.
- ovf  output  1  signed overflow; present only with SERIAL_HALF_SUB_OVF_EN.

## Operation
- State machine: IDLE → SHIFT → DONE → IDLE.
- IDLE
  - in_ready=1.
  - On in_valid && in_ready: latch a into shift register A, b into B, bin into borrow FF; clear bit counter and diff register; go to SHIFT.
- SHIFT (WIDTH cycles)
  - Each cycle i computes d = A[0] ^ B[0] ^ brw and brw' = (~A[0] & B[0]) | (~(A[0] ^ B[0]) & brw).
  - d shifts into the diff register MSB with a right shift, so bit i lands at position i after WIDTH shifts.
  - A and B shift right; brw ← brw'.
  - Counter reaching WIDTH−1 → DONE.
- DONE
  - out_valid=1; diff and bout (final brw) are held stable.
  - On out_valid && out_ready → IDLE.
- in_valid outside IDLE is ignored; operands are not queued.
- a, b, bin are sampled only at the accept edge; later changes have no effect.
- Arithmetic is unsigned modulo 2^WIDTH. bout equals the borrow out of the MSB stage.

## Timing
- Reset values (rst_n=0 at a rising edge): state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, bout=0, ovf=0, counter=0, borrow FF=0.
- Reset mid-SHIFT or mid-DONE abandons the operation; no result is emitted.
- Accept at edge T:
  - busy=1 from T through edge T+WIDTH.
  - out_valid=1 after edge T+WIDTH.
- Latency from accept to out_valid is WIDTH cycles.
- out_valid stays high with diff/bout constant until the output handshake, with no limit on backpressure.
- Output handshake at edge U: out_valid=0 and in_ready=1 after U. The earliest next accept is edge U+1.
- Minimum period is WIDTH+2 cycles per operation.
- in_ready and out_valid are never high together.

## Configuration
- SERIAL_HALF_SUB_OVF_EN defined:
  - Port ovf exists.
  - ovf = (a[MSB] ^ b[MSB]) & (diff[MSB] ^ a[MSB]), evaluated on the latched operand MSBs.
  - ovf is registered at the final SHIFT cycle and valid alongside out_valid; it resets to 0.
- Macro undefined: port ovf and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, bin=0, out_ready=1 → out_valid exactly 8 cycles after accept; diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0.
- Backpressure: out_ready=0 for 20 cycles after out_valid → diff/bout/out_valid stable and in_ready=0; release → in_ready=1 next cycle.
- During SHIFT, drive in_valid=1 with a new a=0xFF and change a/b every cycle → result still reflects the originally accepted operands; the new request is not taken until IDLE.
- rst_n=0 for one edge at SHIFT cycle 3 → after that edge in_ready=1, out_valid=0, diff=0; a fresh a=0x03, b=0x05 gives diff=0xFE, bout=1.
- With SERIAL_HALF_SUB_OVF_EN: a=0x80, b=0x01 → diff=0x7F, ovf=1; a=0x7F, b=0xFF → diff=0x80, ovf=1; a=0x05, b=0x03 → ovf=0.
